// File: rtl/mem_bank_sleep_ctrl.sv
// Per-bank sleep/wake controller between one requester and a banked memory.
// Requests pass through combinationally; a request to a non-awake bank is stalled until it wakes.
module mem_bank_sleep_ctrl #(
  parameter int NUM_BANKS   = 4,
  parameter int BANK_SIZE   = 256,
  parameter int WIDTH       = 32,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 4,
  localparam int AW = $clog2(NUM_BANKS * BANK_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [AW-1:0]        req_addr,
  input  logic [WIDTH-1:0]     req_wdata,
  input  logic [NUM_BANKS-1:0] force_sleep,
  output logic                 mem_wr_en,
  output logic [AW-1:0]        mem_addr,
  output logic [WIDTH-1:0]     mem_wr_data,
  output logic [NUM_BANKS-1:0] bank_sleep
);

  localparam int BW   = $clog2(NUM_BANKS);
  localparam int MAXC = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {SLEEP, WAKING, AWAKE} state_t;

  logic [BW-1:0]        tgt;
  logic [NUM_BANKS-1:0] awake;
  logic                 accept;

  assign tgt         = req_addr[AW-1 -: BW];
  assign req_ready   = req_valid && awake[tgt] && !force_sleep[tgt];
  assign accept      = req_valid && req_ready;
  assign mem_wr_en   = accept && req_wr;
  assign mem_addr    = req_addr;
  assign mem_wr_data = req_wdata;

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    state_t         state_q, state_d;
    logic [CW-1:0]  idle_q, idle_d;
    logic [CW-1:0]  wake_q, wake_d;
    logic           hit;

    assign hit           = (tgt == BW'(i));
    assign bank_sleep[i] = (state_q == SLEEP);
    assign awake[i]      = (state_q == AWAKE);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= SLEEP;
        idle_q  <= '0;
        wake_q  <= '0;
      end else begin
        state_q <= state_d;
        idle_q  <= idle_d;
        wake_q  <= wake_d;
      end
    end

    always_comb begin
      state_d = state_q;
      idle_d  = idle_q;
      wake_d  = wake_q;
      // Software override dominates everything, including a same-cycle wake request.
      if (force_sleep[i]) begin
        state_d = SLEEP;
        idle_d  = '0;
        wake_d  = '0;
      end else begin
        case (state_q)
          SLEEP: begin
            if (req_valid && hit) begin
              state_d = WAKING;
              wake_d  = CW'(WAKE_CYCLES - 1);
            end
          end
          WAKING: begin
            if (wake_q == '0) begin
              state_d = AWAKE;
              idle_d  = '0;
            end else begin
              wake_d = wake_q - CW'(1);
            end
          end
          AWAKE: begin
            // An accept on the terminal idle cycle keeps the bank awake.
            if (accept && hit) begin
              idle_d = '0;
            end else if (idle_q >= CW'(IDLE_CYCLES - 1)) begin
              state_d = SLEEP;
              idle_d  = '0;
            end else begin
              idle_d = idle_q + CW'(1);
            end
          end
          default: state_d = SLEEP;
        endcase
      end
    end
  end

endmodule
